// File: rtl/nibble_packer.sv
// Packs NUM DATA_W-bit nibbles (lane 0 first) into WORD_W-bit words queued in a DEPTH-entry output FIFO; flush emits a partial word.
// Latency: the word-completing nibble accepted at edge k appears on out_valid in the cycle after edge k when the FIFO was empty.
// Backpressure: in_ready drops only when the last lane is pending and the FIFO is full; flushes wait for space and never see out_ready combinationally.
module nibble_packer #(
  parameter  int DATA_W = 4,
  parameter  int NUM    = 4,
  parameter  int DEPTH  = 2,
  localparam int WORD_W = DATA_W * NUM,
  localparam int CW     = $clog2(NUM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [CW-1:0]     out_count,
  input  logic              out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  // accumulator state
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              flush_pending_q, flush_pending_d;

  // output FIFO state
  logic [WORD_W-1:0] dat_mem_q [DEPTH];
  logic [WORD_W-1:0] dat_mem_d [DEPTH];
  logic [CW-1:0]     cnt_mem_q [DEPTH];
  logic [CW-1:0]     cnt_mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [WORD_W-1:0] last_dat_q, last_dat_d;
  logic [CW-1:0]     last_cnt_q, last_cnt_d;

  // datapath helpers
  logic              fifo_full, fifo_empty;
  logic              accept, complete, flush_req, flush_go, push, pop;
  logic [WORD_W-1:0] acc_ins;
  logic [CW-1:0]     cnt_ins;

  assign fifo_full  = (occ_q == OW'(DEPTH));
  assign fifo_empty = (occ_q == '0);
  // Registered state only: the last lane waits for FIFO space, earlier lanes never stall.
  assign in_ready   = (cnt_q != CW'(NUM - 1)) || !fifo_full;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? last_dat_q : dat_mem_q[rd_ptr_q];
  assign out_count  = fifo_empty ? last_cnt_q : cnt_mem_q[rd_ptr_q];

  // Accumulator: insert the accepted nibble, then decide whether a word (full or flushed) leaves this edge.
  always_comb begin
    accept          = in_valid && in_ready;
    acc_ins         = acc_q;
    for (int i = 0; i < NUM; i++) begin
      if (accept && (cnt_q == CW'(i))) begin
        acc_ins[i*DATA_W +: DATA_W] = in_data;
      end
    end
    cnt_ins         = cnt_q + CW'(accept);
    complete        = accept && (cnt_q == CW'(NUM - 1));
    flush_req       = flush_pending_q || flush;
    flush_go        = flush_req && !fifo_full;
    // An empty flush is dropped; a completion coinciding with a flush yields one full word.
    push            = complete || (flush_go && (cnt_ins != '0));
    cnt_d           = push ? '0 : cnt_ins;
    acc_d           = push ? '0 : acc_ins;
    flush_pending_d = flush_go ? 1'b0 : flush_req;
  end

  // FIFO: push at the write pointer, pop the head, remember the last popped entry for the idle outputs.
  always_comb begin
    pop        = !fifo_empty && out_ready;
    dat_mem_d  = dat_mem_q;
    cnt_mem_d  = cnt_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    last_dat_d = last_dat_q;
    last_cnt_d = last_cnt_q;
    if (push) begin
      dat_mem_d[wr_ptr_q] = acc_ins;
      cnt_mem_d[wr_ptr_q] = cnt_ins;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      last_dat_d = dat_mem_q[rd_ptr_q];
      last_cnt_d = cnt_mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      occ_d = occ_q + OW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OW'(1);
    end
  end

  // State registers with synchronous active-low reset discarding partial and queued words.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q           <= '0;
      acc_q           <= '0;
      flush_pending_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      last_dat_q      <= '0;
      last_cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_mem_q[i] <= '0;
        cnt_mem_q[i] <= '0;
      end
    end else begin
      cnt_q           <= cnt_d;
      acc_q           <= acc_d;
      flush_pending_q <= flush_pending_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      last_dat_q      <= last_dat_d;
      last_cnt_q      <= last_cnt_d;
      dat_mem_q       <= dat_mem_d;
      cnt_mem_q       <= cnt_mem_d;
    end
  end

endmodule
